axi_mem_responder: RTL and testbench

- AXI4 responder endpoint: accepts write and read bursts from an upstream initiator and returns B and R responses, backed by an internal flop-based memory of 512-bit lines.
- Terminates an axi_bus_t link, typically placed downstream of the AXI register slices, as a simulation and bring-up memory target.
- Write and read paths run independently and concurrently; each handles one burst at a time.

---
 rtl/axi_mem_responder_if.sv | 47 ++++
 rtl/axi_mem_responder.sv | 193 +++++++++++++++++++
 tb/tb_axi_mem_responder.sv | 272 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/axi_mem_responder_if.sv
// AXI4 bundle between an upstream initiator and axi_mem_responder.
// The master modport is the responder's view: it drives the ready, B and R signals.
interface axi_mem_responder_if;
    logic         awvalid;
    logic         awready;
    logic [15:0]  awid;
    logic [63:0]  awaddr;
    logic [7:0]   awlen;
    logic [2:0]   awsize;
    logic         wvalid;
    logic         wready;
    logic [511:0] wdata;
    logic [63:0]  wstrb;
    logic         wlast;
    logic         bvalid;
    logic         bready;
    logic [15:0]  bid;
    logic [1:0]   bresp;
    logic         arvalid;
    logic         arready;
    logic [15:0]  arid;
    logic [63:0]  araddr;
    logic [7:0]   arlen;
    logic [2:0]   arsize;
    logic         rvalid;
    logic         rready;
    logic [15:0]  rid;
    logic [511:0] rdata;
    logic [1:0]   rresp;
    logic         rlast;

    modport master (
        input  awvalid, awid, awaddr, awlen, awsize,
        input  wvalid, wdata, wstrb, wlast, bready,
        input  arvalid, arid, araddr, arlen, arsize, rready,
        output awready, wready, bvalid, bid, bresp,
        output arready, rvalid, rid, rdata, rresp, rlast
    );

    modport slave (
        output awvalid, awid, awaddr, awlen, awsize,
        output wvalid, wdata, wstrb, wlast, bready,
        output arvalid, arid, araddr, arlen, arsize, rready,
        input  awready, wready, bvalid, bid, bresp,
        input  arready, rvalid, rid, rdata, rresp, rlast
    );
endinterface

// File: rtl/axi_mem_responder.sv
// AXI4 memory target: independent write and read burst engines over a
// flop-based array of 512-bit lines, one 64-byte beat per line.
module axi_mem_responder #(
    parameter int MEM_LD = 4,
    parameter bit ERR_EN = 1'b1
) (
    input  logic                       clk,
    input  logic                       rst_n,
    axi_mem_responder_if.master        axi_s,
    output logic [31:0]                wr_beats,
    output logic [31:0]                rd_beats
);
    localparam int         DEPTH       = 1 << MEM_LD;
    localparam logic [1:0] W_IDLE      = 2'd0;
    localparam logic [1:0] W_DATA      = 2'd1;
    localparam logic [1:0] W_RESP      = 2'd2;
    localparam logic [0:0] R_IDLE      = 1'b0;
    localparam logic [0:0] R_DATA      = 1'b1;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    logic [511:0]      r_mem [DEPTH];
    logic [1:0]        r_wstate;
    logic              r_awready, r_wready, r_bvalid, r_woor, r_wmis;
    logic [15:0]       r_bid;
    logic [1:0]        r_bresp;
    logic [MEM_LD-1:0] r_wline;
    logic [7:0]        r_wlen, r_wbeat;
    logic [0:0]        r_rstate;
    logic              r_arready, r_rvalid, r_rlast, r_roor;
    logic [15:0]       r_rid;
    logic [1:0]        r_rresp;
    logic [MEM_LD-1:0] r_rline;
    logic [7:0]        r_rlen, r_rbeat;

    logic w_aw_oor, w_ar_oor, w_wfire, w_wlast_beat, w_wlast_err, w_rfire;
    logic w_unused;

    assign w_aw_oor     = |axi_s.awaddr[63:6+MEM_LD];
    assign w_ar_oor     = |axi_s.araddr[63:6+MEM_LD];
    assign w_wfire      = r_wready && axi_s.wvalid;
    assign w_wlast_beat = (r_wbeat == r_wlen);
    assign w_wlast_err  = (axi_s.wlast != w_wlast_beat);
    assign w_rfire      = r_rvalid && axi_s.rready;
    assign w_unused     = ^{axi_s.awsize, axi_s.arsize, axi_s.awaddr[5:0], axi_s.araddr[5:0]};

    assign axi_s.awready = r_awready;
    assign axi_s.wready  = r_wready;
    assign axi_s.bvalid  = r_bvalid;
    assign axi_s.bid     = r_bid;
    assign axi_s.bresp   = r_bresp;
    assign axi_s.arready = r_arready;
    assign axi_s.rvalid  = r_rvalid;
    assign axi_s.rid     = r_rid;
    assign axi_s.rresp   = r_rresp;
    assign axi_s.rlast   = r_rlast;
    // Combinational line read so a same-cycle write to this line is seen only after the edge.
    assign axi_s.rdata   = (r_rvalid && !r_roor) ? r_mem[r_rline] : 512'd0;

    // Write burst FSM: AW capture, W beat tracking, B response.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wstate  <= W_IDLE;
            r_awready <= 1'b1;
            r_wready  <= 1'b0;
            r_bvalid  <= 1'b0;
            r_bid     <= 16'd0;
            r_bresp   <= RESP_OKAY;
            r_wline   <= '0;
            r_wlen    <= 8'd0;
            r_wbeat   <= 8'd0;
            r_woor    <= 1'b0;
            r_wmis    <= 1'b0;
            wr_beats  <= 32'd0;
        end else begin
            case (r_wstate)
                W_IDLE: begin
                    if (axi_s.awvalid) begin
                        r_bid     <= axi_s.awid;
                        r_wline   <= axi_s.awaddr[6+MEM_LD-1:6];
                        r_wlen    <= axi_s.awlen;
                        r_wbeat   <= 8'd0;
                        r_woor    <= w_aw_oor;
                        r_wmis    <= 1'b0;
                        r_awready <= 1'b0;
                        r_wready  <= 1'b1;
                        r_wstate  <= W_DATA;
                    end
                end
                W_DATA: begin
                    if (w_wfire) begin
                        wr_beats <= wr_beats + 32'd1;
                        r_wline  <= r_wline + MEM_LD'(1);
                        r_wbeat  <= r_wbeat + 8'd1;
                        if (w_wlast_err) begin
                            r_wmis <= 1'b1;
                        end
                        // Burst length comes from awlen alone; wlast only feeds the error flag.
                        if (w_wlast_beat) begin
                            r_wready <= 1'b0;
                            r_bvalid <= 1'b1;
                            r_bresp  <= (ERR_EN && (r_woor || r_wmis || w_wlast_err)) ? RESP_SLVERR : RESP_OKAY;
                            r_wstate <= W_RESP;
                        end
                    end
                end
                W_RESP: begin
                    if (axi_s.bready) begin
                        r_bvalid  <= 1'b0;
                        r_awready <= 1'b1;
                        r_wstate  <= W_IDLE;
                    end
                end
                default: begin
                    r_wstate  <= W_IDLE;
                    r_awready <= 1'b1;
                    r_wready  <= 1'b0;
                    r_bvalid  <= 1'b0;
                end
            endcase
        end
    end

    // Memory array: byte-strobed writes for in-range beats only.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int l = 0; l < DEPTH; l++) begin
                r_mem[l] <= 512'd0;
            end
        end else if (w_wfire && !r_woor) begin
            for (int b = 0; b < 64; b++) begin
                if (axi_s.wstrb[b]) begin
                    r_mem[r_wline][b*8 +: 8] <= axi_s.wdata[b*8 +: 8];
                end
            end
        end
    end

    // Read burst FSM: AR capture, R beat sequencing held under backpressure.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rstate  <= R_IDLE;
            r_arready <= 1'b1;
            r_rvalid  <= 1'b0;
            r_rlast   <= 1'b0;
            r_roor    <= 1'b0;
            r_rid     <= 16'd0;
            r_rresp   <= RESP_OKAY;
            r_rline   <= '0;
            r_rlen    <= 8'd0;
            r_rbeat   <= 8'd0;
            rd_beats  <= 32'd0;
        end else begin
            case (r_rstate)
                R_IDLE: begin
                    if (axi_s.arvalid) begin
                        r_rid     <= axi_s.arid;
                        r_rline   <= axi_s.araddr[6+MEM_LD-1:6];
                        r_rlen    <= axi_s.arlen;
                        r_rbeat   <= 8'd0;
                        r_roor    <= w_ar_oor;
                        r_rresp   <= (ERR_EN && w_ar_oor) ? RESP_SLVERR : RESP_OKAY;
                        r_rlast   <= (axi_s.arlen == 8'd0);
                        r_arready <= 1'b0;
                        r_rvalid  <= 1'b1;
                        r_rstate  <= R_DATA;
                    end
                end
                R_DATA: begin
                    if (w_rfire) begin
                        rd_beats <= rd_beats + 32'd1;
                        if (r_rlast) begin
                            r_rvalid  <= 1'b0;
                            r_rlast   <= 1'b0;
                            r_arready <= 1'b1;
                            r_rstate  <= R_IDLE;
                        end else begin
                            r_rline <= r_rline + MEM_LD'(1);
                            r_rbeat <= r_rbeat + 8'd1;
                            r_rlast <= ((r_rbeat + 8'd1) == r_rlen);
                        end
                    end
                end
                default: begin
                    r_rstate  <= R_IDLE;
                    r_arready <= 1'b1;
                    r_rvalid  <= 1'b0;
                    r_rlast   <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_axi_mem_responder.sv
// Scoreboard bench for axi_mem_responder: a line-level memory model predicts
// B and R responses, which a negedge monitor pops and compares.
module tb_axi_mem_responder;
    typedef struct {
        logic [511:0] d;
        logic [15:0]  id;
        logic [1:0]   resp;
        logic         last;
    } rexp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [31:0] wr_beats, rd_beats;

    axi_mem_responder_if bus ();

    axi_mem_responder #(.MEM_LD(4), .ERR_EN(1'b1)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .axi_s    (bus),
        .wr_beats (wr_beats),
        .rd_beats (rd_beats)
    );

    always #5 clk = ~clk;

    int           n_chk = 0;
    int           n_err = 0;
    int           exp_wr = 0;
    int           exp_rd = 0;
    logic [511:0] mdl [16];
    logic [17:0]  b_q [$];
    rexp_t        r_q [$];
    logic         r_stall = 1'b0;
    logic [511:0] r_held;
    logic [511:0] ones_d = {512{1'b1}};
    logic [63:0]  ones_s = {64{1'b1}};

    task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [511:0] pat(input logic [31:0] s);
        logic [511:0] p;
        for (int i = 0; i < 16; i++) p[i*32 +: 32] = s * 32'h9E3779B1 + 32'(i);
        return p;
    endfunction

    // Monitor: compare each B/R handshake against the scoreboard, and check R stability under stall.
    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.bvalid && bus.bready) begin
                if (b_q.size() == 0) begin
                    chk("b_unexpected", 512'(b_q.size()), 512'd1);
                end else begin
                    logic [17:0] e;
                    e = b_q.pop_front();
                    chk("bid", bus.bid, e[17:2]);
                    chk("bresp", bus.bresp, e[1:0]);
                end
            end
            if (bus.rvalid) begin
                if (r_stall) chk("r_stable", bus.rdata, r_held);
                if (bus.rready) begin
                    r_stall = 1'b0;
                    if (r_q.size() == 0) begin
                        chk("r_unexpected", 512'(r_q.size()), 512'd1);
                    end else begin
                        rexp_t e;
                        e = r_q.pop_front();
                        chk("rdata", bus.rdata, e.d);
                        chk("rid", bus.rid, e.id);
                        chk("rresp", bus.rresp, e.resp);
                        chk("rlast", bus.rlast, e.last);
                    end
                end else begin
                    r_stall = 1'b1;
                    r_held  = bus.rdata;
                end
            end else begin
                r_stall = 1'b0;
            end
        end else begin
            r_stall = 1'b0;
        end
    end

    task automatic wr_burst(input logic [63:0] addr, input logic [7:0] len, input logic [15:0] id,
                            input logic [511:0] base, input logic [63:0] strb, input int bad_last);
        logic         oor;
        logic [3:0]   line;
        logic [511:0] d;
        int           n;
        oor  = |addr[63:10];
        line = addr[9:6];
        b_q.push_back({id, (oor || bad_last >= 0) ? 2'b10 : 2'b00});
        exp_wr += int'(len) + 1;
        bus.awvalid = 1'b1; bus.awaddr = addr; bus.awlen = len; bus.awid = id; bus.awsize = 3'd6;
        n = 0;
        do begin @(negedge clk); n++; end while (!bus.awready && n < 100);
        chk("aw_timeout", 512'(bus.awready), 512'd1);
        @(posedge clk); #1;
        bus.awvalid = 1'b0;
        for (int b = 0; b <= int'(len); b++) begin
            d = base + 512'(b);
            bus.wvalid = 1'b1; bus.wdata = d; bus.wstrb = strb;
            bus.wlast  = (bad_last >= 0) ? (b == bad_last) : (b == int'(len));
            n = 0;
            do begin @(negedge clk); n++; end while (!bus.wready && n < 100);
            chk("w_timeout", 512'(bus.wready), 512'd1);
            @(posedge clk); #1;
            if (!oor) begin
                for (int k = 0; k < 64; k++) if (strb[k]) mdl[line][k*8 +: 8] = d[k*8 +: 8];
            end
            line = line + 4'd1;
        end
        bus.wvalid = 1'b0; bus.wlast = 1'b0;
    endtask

    task automatic rd_burst(input logic [63:0] addr, input logic [7:0] len, input logic [15:0] id);
        logic       oor;
        logic [3:0] line;
        rexp_t      e;
        int         n;
        oor  = |addr[63:10];
        line = addr[9:6];
        for (int b = 0; b <= int'(len); b++) begin
            e.d = oor ? 512'd0 : mdl[line];
            e.id = id; e.resp = oor ? 2'b10 : 2'b00; e.last = (b == int'(len));
            r_q.push_back(e);
            line = line + 4'd1;
        end
        exp_rd += int'(len) + 1;
        bus.arvalid = 1'b1; bus.araddr = addr; bus.arlen = len; bus.arid = id; bus.arsize = 3'd6;
        n = 0;
        do begin @(negedge clk); n++; end while (!bus.arready && n < 100);
        chk("ar_timeout", 512'(bus.arready), 512'd1);
        @(posedge clk); #1;
        bus.arvalid = 1'b0;
    endtask

    task automatic wait_b();
        int n = 0;
        while (b_q.size() != 0 && n < 200) begin @(negedge clk); n++; end
        chk("b_done", 512'(b_q.size()), 512'd0);
        @(posedge clk); #1;
    endtask

    task automatic wait_r();
        int n = 0;
        while (r_q.size() != 0 && n < 200) begin @(negedge clk); n++; end
        chk("r_done", 512'(r_q.size()), 512'd0);
        @(posedge clk); #1;
    endtask

    task automatic chk_counts();
        @(negedge clk);
        chk("wr_beats", wr_beats, 512'(exp_wr));
        chk("rd_beats", rd_beats, 512'(exp_rd));
        @(posedge clk); #1;
    endtask

    initial begin
        int n;
        for (int i = 0; i < 16; i++) mdl[i] = 512'd0;
        bus.awvalid = 1'b0; bus.awid = 16'd0; bus.awaddr = 64'd0; bus.awlen = 8'd0; bus.awsize = 3'd0;
        bus.wvalid = 1'b0; bus.wdata = 512'd0; bus.wstrb = 64'd0; bus.wlast = 1'b0; bus.bready = 1'b1;
        bus.arvalid = 1'b0; bus.arid = 16'd0; bus.araddr = 64'd0; bus.arlen = 8'd0; bus.arsize = 3'd0;
        bus.rready = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        @(negedge clk);
        chk("rst_awready", bus.awready, 512'd1);
        chk("rst_arready", bus.arready, 512'd1);
        chk("rst_wready", bus.wready, 512'd0);
        chk("rst_bvalid", bus.bvalid, 512'd0);
        chk("rst_rvalid", bus.rvalid, 512'd0);
        chk("rst_bid", {bus.bid, bus.bresp}, 512'd0);
        chk("rst_r", {bus.rid, bus.rresp, bus.rlast, bus.rdata}, 512'd0);
        chk("rst_cnt", {wr_beats, rd_beats}, 512'd0);
        @(posedge clk); #1;

        // Single write then read.
        wr_burst(64'h40, 8'd0, 16'h5, pat(32'hA), ones_s, -1);
        wait_b();
        rd_burst(64'h40, 8'd0, 16'h7);
        wait_r();
        chk_counts();

        // Burst wrapping from line 15 to line 2.
        wr_burst(64'h3C0, 8'd3, 16'h12, pat(32'h100), ones_s, -1);
        wait_b();
        rd_burst(64'h3C0, 8'd3, 16'h13);
        wait_r();

        // Byte strobes on line 2.
        wr_burst(64'h80, 8'd0, 16'h21, ones_d, ones_s, -1);
        wait_b();
        wr_burst(64'h80, 8'd0, 16'h22, 512'd0, 64'h0F, -1);
        wait_b();
        rd_burst(64'h80, 8'd0, 16'h23);
        wait_r();
        chk("strobe_model", mdl[2], {{480{1'b1}}, 32'd0});

        // Error cases: out-of-range write, wlast mismatch, out-of-range read.
        wr_burst(64'h1_0000_0000, 8'd0, 16'h31, pat(32'h5), ones_s, -1);
        wait_b();
        rd_burst(64'h0, 8'd0, 16'h34);
        wait_r();
        wr_burst(64'h100, 8'd1, 16'h32, pat(32'h6), ones_s, 0);
        wait_b();
        rd_burst(64'h100, 8'd1, 16'h35);
        wait_r();
        rd_burst(64'h1_0000_0040, 8'd0, 16'h33);
        wait_r();
        chk_counts();

        // B backpressure.
        bus.bready = 1'b0;
        wr_burst(64'h140, 8'd0, 16'h41, pat(32'h7), ones_s, -1);
        n = 0;
        do begin @(negedge clk); n++; end while (!bus.bvalid && n < 100);
        chk("bvalid_wait", bus.bvalid, 512'd1);
        repeat (5) begin
            @(negedge clk);
            chk("b_hold", {bus.bvalid, bus.awready}, 512'b10);
        end
        bus.bready = 1'b1;
        wait_b();

        // R backpressure on an 8-beat read with rready toggling.
        rd_burst(64'h0, 8'd7, 16'h42);
        n = 0;
        while (r_q.size() != 0 && n < 200) begin
            @(posedge clk); #1;
            bus.rready = ~bus.rready;
            n++;
        end
        bus.rready = 1'b1;
        wait_r();
        chk_counts();

        // Asynchronous reset during beat 2 of a 4-beat read.
        rd_burst(64'h0, 8'd3, 16'h51);
        n = 0;
        while (r_q.size() > 2 && n < 100) begin @(negedge clk); n++; end
        chk("rst_burst_wait", 512'(r_q.size()), 512'd2);
        @(posedge clk); #3;
        rst_n = 1'b0;
        #1;
        chk("async_rvalid", bus.rvalid, 512'd0);
        r_q.delete(); b_q.delete();
        for (int i = 0; i < 16; i++) mdl[i] = 512'd0;
        exp_wr = 0; exp_rd = 0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_ready", {bus.arready, bus.awready}, 512'b11);
        @(posedge clk); #1;
        chk_counts();
        rd_burst(64'h3C0, 8'd3, 16'h52);
        wait_r();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
